dcpu16_seq: RTL and testbench
=============================

Name: dcpu16_seq

Overview:
Instruction sequencer for the DCPU16 core. It is the control end of the ALU interface and drives the ALU's opcode/enable pair. It fetches instruction words and next-word operands over the bus, decodes the opcode and a/b fields, strobes the ALU, then raises the writeback strobe. It also evaluates IFE/IFN/IFG/IFB and skips the following instruction when the condition is false.

Parameters:
RST_PC, 16'h0000, program counter value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
bus_adr  out  16  word address for fetch; equals pc while bus_stb=1
bus_stb  out  1  fetch request; held until bus_ack
bus_dti  in  16  fetched word; sampled when bus_stb & bus_ack
bus_ack  in  1  fetch complete; ignored when bus_stb=0
alu_opc  out  4  opcode to ALU (ir[3:0])
alu_ena  out  1  ALU enable; one-cycle pulse per instruction
ea  out  6  decoded a field (ir[9:4])
eb  out  6  decoded b field (ir[15:10])
nwa  out  16  next word latched for a
nwb  out  16  next word latched for b
src  in  16  resolved a operand value, valid in EX
tgt  in  16  resolved b operand value, valid in EX
wb_stb  out  1  writeback strobe; ALU regR/regO valid this cycle
pc_wre  in  1  writeback targets PC; sampled in WB only
pc_dti  in  16  new PC value when pc_wre
pc  out  16  program counter

Behaviour:
- Reset state: FE, pc=RST_PC. ir, nwa, nwb = 0. alu_ena, wb_stb, bus_stb = 0.
- Reset mid-operation aborts immediately; an outstanding ack is dropped.
- bus_stb drops combinationally with rst.
- Next-word rule needs(f): f in 0x10..0x17, f=0x1e or f=0x1f. All other field values need no bus word.
- States:
  - FE: bus_stb=1, bus_adr=pc. On ack: ir<=bus_dti, pc<=pc+1. Then go NA if needs(a), else NB if needs(b), else EX.
  - NA: bus_stb=1. On ack: nwa<=bus_dti, pc<=pc+1. Then go NB if needs(b), else EX.
  - NB: bus_stb=1. On ack: nwb<=bus_dti, pc<=pc+1. Then go EX.
  - EX: alu_ena=1 for exactly one cycle.
    - opc 0x1..0xB: go WB.
    - opc 0xC..0xF: evaluate the condition on src/tgt. IFE src==tgt; IFN src!=tgt; IFG src>tgt (unsigned); IFB (src&tgt)!=0. True: go FE. False: go SK.
    - opc 0x0 (non-basic, unimplemented in this revision): NOP, go FE, no wb_stb.
  - WB: wb_stb=1 for one cycle. If pc_wre, pc<=pc_dti; this overrides any increment. Then go FE.
  - SK: bus_stb=1 at pc. On ack: pc<=pc+1+needs(a')+needs(b'), where a'/b' are fields of bus_dti. ir is unchanged. Then go FE.
- A skipped IF* does not chain (spec 1.1). Skip exactly one instruction.
- bus_ack low: hold state; bus_adr/bus_stb stable; no pc change.
- pc arithmetic is 16-bit modulo; 0xFFFF+1 wraps to 0x0000.
- Latency with zero-wait bus: 1+N fetch cycles + EX + WB (if writing). SET with no next words: 3 cycles.
- alu_opc, ea, eb, nwa, nwb hold last values outside EX/WB.

Decomposition:
- Shared package dcpu16_pkg holds:
  - opcode constants OPC_SET..OPC_IFB;
  - operand field constants (FLD_NWREG base 0x10, FLD_NWIND 0x1e, FLD_NWLIT 0x1f, FLD_PC 0x1c);
  - state encoding.
- One natural sub-module: dcpu16_cond, combinational IF* evaluator (opc, src, tgt -> true).
- The needs() decode is a package function used by both FE/NA routing and SK.

Test Plan:
- Reset: rst pulse mid-cycle -> pc=0x0000, bus_stb=0 during rst; after release bus_stb=1, bus_adr=0x0000.
- SET A,lit-next: mem[0]=0x7C01, mem[1]=0x0030 -> fetches at 0 then 1; nwb=0x0030; alu_ena with opc=1 for one cycle; wb_stb next cycle; pc=0x0002.
- ADD [nw+A],nw: mem[0]=0x7D02, mem[1]=0x1000, mem[2]=0x0005 -> nwa=0x1000, nwb=0x0005, opc=2; pc=0x0003.
- IFE false/true:
  - mem[0]=0x800C, src=5, tgt=0 -> SK fetches mem[1]=0x7C01, pc jumps to 0x0003, no wb_stb.
  - Same with src=tgt=0 -> next fetch at 0x0001.
- Wait states: bus_ack low 5 cycles in FE and NB -> bus_adr/bus_stb stable, no alu_ena until acks arrive.
- PC write and reset mid-NA:
  - mem[0]=0x7DC1, pc_wre=1, pc_dti=0x0040 in WB -> next fetch at 0x0040.
  - rst during NA -> immediate FE, pc=0.

Source files
------------

// File: rtl/dcpu16_pkg.sv
// Shared DCPU16 sequencer definitions: opcodes, operand field codes, FSM states.
package dcpu16_pkg;

  localparam int unsigned DW = 16;  // data / address width
  localparam int unsigned OW = 4;   // basic opcode width
  localparam int unsigned FW = 6;   // operand field width

  typedef enum logic [OW-1:0] {
    OPC_NBI = 4'h0,
    OPC_SET = 4'h1,
    OPC_ADD = 4'h2,
    OPC_SUB = 4'h3,
    OPC_MUL = 4'h4,
    OPC_DIV = 4'h5,
    OPC_MOD = 4'h6,
    OPC_SHL = 4'h7,
    OPC_SHR = 4'h8,
    OPC_AND = 4'h9,
    OPC_BOR = 4'hA,
    OPC_XOR = 4'hB,
    OPC_IFE = 4'hC,
    OPC_IFN = 4'hD,
    OPC_IFG = 4'hE,
    OPC_IFB = 4'hF
  } opc_t;

  localparam logic [FW-1:0] FLD_NWREG = 6'h10;  // [nw+reg] block 0x10..0x17
  localparam logic [FW-1:0] FLD_NWIND = 6'h1e;  // [nw]
  localparam logic [FW-1:0] FLD_NWLIT = 6'h1f;  // nw literal
  localparam logic [FW-1:0] FLD_PC    = 6'h1c;  // PC register

  typedef enum logic [2:0] {
    ST_FE,
    ST_NA,
    ST_NB,
    ST_EX,
    ST_WB,
    ST_SK
  } state_t;

  // True when an operand field consumes one extra instruction word.
  function automatic logic needs(input logic [FW-1:0] f);
    return (f[5:3] == FLD_NWREG[5:3]) || (f == FLD_NWIND) || (f == FLD_NWLIT);
  endfunction

endpackage

// File: rtl/dcpu16_cond.sv
// Combinational IFE/IFN/IFG/IFB condition evaluator.
module dcpu16_cond
  import dcpu16_pkg::*;
(
  input  logic [OW-1:0] opc,
  input  logic [DW-1:0] src,
  input  logic [DW-1:0] tgt,
  output logic          is_true_c
);

  // Condition result for the conditional opcodes; zero for anything else.
  always_comb begin
    is_true_c = 1'b0;
    case (opc)
      OPC_IFE: is_true_c = (src == tgt);
      OPC_IFN: is_true_c = (src != tgt);
      OPC_IFG: is_true_c = (src > tgt);
      OPC_IFB: is_true_c = ((src & tgt) != '0);
      default: is_true_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/dcpu16_seq.sv
// DCPU16 instruction sequencer: fetch, next-word fetch, ALU strobe, writeback, skip.
module dcpu16_seq
  import dcpu16_pkg::*;
#(
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] bus_adr,
  output logic          bus_stb,
  input  logic [DW-1:0] bus_dti,
  input  logic          bus_ack,
  output logic [OW-1:0] alu_opc,
  output logic          alu_ena,
  output logic [FW-1:0] ea,
  output logic [FW-1:0] eb,
  output logic [DW-1:0] nwa,
  output logic [DW-1:0] nwb,
  input  logic [DW-1:0] src,
  input  logic [DW-1:0] tgt,
  output logic          wb_stb,
  input  logic          pc_wre,
  input  logic [DW-1:0] pc_dti,
  output logic [DW-1:0] pc
);

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, nwa_q, nwb_q;
  logic          ir_ld, nwa_ld, nwb_ld;
  logic          fetch_c;
  logic          is_true_c;
  logic [OW-1:0] opc_c;
  logic [FW-1:0] fa_c, fb_c;

  assign opc_c = ir_q[3:0];
  assign fa_c  = bus_dti[9:4];
  assign fb_c  = bus_dti[15:10];

  dcpu16_cond u_cond (
    .opc       (opc_c),
    .src       (src),
    .tgt       (tgt),
    .is_true_c (is_true_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FE;
    else     state_q <= state_d;
  end

  // Next-state, bus request and datapath load decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_ld   = 1'b0;
    nwa_ld  = 1'b0;
    nwb_ld  = 1'b0;
    fetch_c = 1'b0;
    case (state_q)
      ST_FE: begin
        fetch_c = 1'b1;
        if (bus_ack) begin
          ir_ld = 1'b1;
          pc_d  = pc_q + DW'(1);
          if (needs(fa_c))      state_d = ST_NA;
          else if (needs(fb_c)) state_d = ST_NB;
          else                  state_d = ST_EX;
        end
      end
      ST_NA: begin
        fetch_c = 1'b1;
        if (bus_ack) begin
          nwa_ld  = 1'b1;
          pc_d    = pc_q + DW'(1);
          state_d = needs(ir_q[15:10]) ? ST_NB : ST_EX;
        end
      end
      ST_NB: begin
        fetch_c = 1'b1;
        if (bus_ack) begin
          nwb_ld  = 1'b1;
          pc_d    = pc_q + DW'(1);
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        if (opc_c == OPC_NBI)      state_d = ST_FE;
        else if (opc_c <= OPC_XOR) state_d = ST_WB;
        else                       state_d = is_true_c ? ST_FE : ST_SK;
      end
      ST_WB: begin
        if (pc_wre) pc_d = pc_dti;
        state_d = ST_FE;
      end
      ST_SK: begin
        // Step over the skipped word and its next words without executing it.
        fetch_c = 1'b1;
        if (bus_ack) begin
          pc_d    = pc_q + DW'(1) + DW'(needs(fa_c)) + DW'(needs(fb_c));
          state_d = ST_FE;
        end
      end
      default: state_d = ST_FE;
    endcase
  end

  // Program counter, instruction and next-word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RST_PC;
      ir_q  <= '0;
      nwa_q <= '0;
      nwb_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (ir_ld)  ir_q  <= bus_dti;
      if (nwa_ld) nwa_q <= bus_dti;
      if (nwb_ld) nwb_q <= bus_dti;
    end
  end

  // Request is masked directly by reset so it drops without waiting for a clock.
  assign bus_stb = fetch_c & ~rst;
  assign bus_adr = pc_q;
  assign alu_ena = (state_q == ST_EX);
  assign wb_stb  = (state_q == ST_WB);
  assign alu_opc = opc_c;
  assign ea      = ir_q[9:4];
  assign eb      = ir_q[15:10];
  assign nwa     = nwa_q;
  assign nwb     = nwb_q;
  assign pc      = pc_q;

endmodule

// File: tb/tb_dcpu16_seq.sv
// Directed self-checking bench for the DCPU16 instruction sequencer.
module tb_dcpu16_seq;
  import dcpu16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_adr;
  logic        bus_stb;
  logic [15:0] bus_dti;
  logic        bus_ack;
  logic [3:0]  alu_opc;
  logic        alu_ena;
  logic [5:0]  ea, eb;
  logic [15:0] nwa, nwb;
  logic [15:0] src = 16'h0, tgt = 16'h0;
  logic        wb_stb;
  logic        pc_wre = 1'b0;
  logic [15:0] pc_dti = 16'h0;
  logic [15:0] pc;

  logic [15:0] mem [0:255];
  logic        ack_en = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int alu_cnt = 0, wb_cnt = 0, alu_cyc = 0, wb_cyc = 0;
  logic [15:0] fetch_q [$];
  logic [3:0]  opc_q [$];

  dcpu16_seq #(.RST_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .bus_adr(bus_adr), .bus_stb(bus_stb), .bus_dti(bus_dti), .bus_ack(bus_ack),
    .alu_opc(alu_opc), .alu_ena(alu_ena), .ea(ea), .eb(eb), .nwa(nwa), .nwb(nwb),
    .src(src), .tgt(tgt), .wb_stb(wb_stb), .pc_wre(pc_wre), .pc_dti(pc_dti), .pc(pc)
  );

  always #5 clk = ~clk;

  // Zero-wait memory unless the bench withholds ack.
  assign bus_ack = bus_stb & ack_en;
  assign bus_dti = mem[bus_adr[7:0]];

  // Event log sampled mid-low-phase, after the bench has driven its inputs.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst) begin
      if (bus_stb && bus_ack) fetch_q.push_back(bus_adr);
      if (alu_ena) begin alu_cnt++; alu_cyc = cyc; opc_q.push_back(alu_opc); end
      if (wb_stb) begin wb_cnt++; wb_cyc = cyc; end
    end
  end

  task automatic clear_logs();
    fetch_q.delete();
    opc_q.delete();
    alu_cnt = 0; wb_cnt = 0; alu_cyc = 0; wb_cyc = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic start();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 16'h7D02; mem[1] = 16'h1000; mem[2] = 16'h0005;
    start();
    run_cycles(3);
    #3 rst = 1'b1;
    #1;
    total++; if (bus_stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b exp=0", bus_stb); end
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", pc); end
    total++; if (nwa !== 16'h0000 || nwb !== 16'h0000) begin bad++; $display("FAIL rst_nw got=%h/%h exp=0000/0000", nwa, nwb); end
    total++; if ({alu_opc, ea, eb} !== 16'h0000) begin bad++; $display("FAIL rst_ir got=%h/%h/%h exp=0/0/0", alu_opc, ea, eb); end
    total++; if (alu_ena !== 1'b0 || wb_stb !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b exp=00", alu_ena, wb_stb); end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    #1;
    total++; if (bus_stb !== 1'b1 || bus_adr !== 16'h0000) begin bad++; $display("FAIL rst_release got=%b@%h exp=1@0000", bus_stb, bus_adr); end
  endtask

  task automatic test_set();
    clear_mem();
    mem[0] = 16'h7C01; mem[1] = 16'h0030;
    start();
    run_cycles(4);
    #1;
    total++; if (fetch_q.size() != 2 || fetch_q[0] !== 16'h0000 || fetch_q[1] !== 16'h0001) begin bad++; $display("FAIL set_fetch got=%0d entries exp=0,1", fetch_q.size()); end
    total++; if (nwb !== 16'h0030) begin bad++; $display("FAIL set_nwb got=%h exp=0030", nwb); end
    total++; if (alu_cnt != 1 || opc_q[0] !== 4'h1) begin bad++; $display("FAIL set_alu got=%0d opc=%h exp=1 opc=1", alu_cnt, opc_q[0]); end
    total++; if (wb_cnt != 1 || wb_cyc != alu_cyc + 1) begin bad++; $display("FAIL set_wb got=%0d@%0d exp=1@%0d", wb_cnt, wb_cyc, alu_cyc + 1); end
    total++; if (pc !== 16'h0002 || bus_adr !== 16'h0002) begin bad++; $display("FAIL set_pc got=%h/%h exp=0002", pc, bus_adr); end
  endtask

  task automatic test_add();
    clear_mem();
    mem[0] = 16'h7D02; mem[1] = 16'h1000; mem[2] = 16'h0005;
    start();
    run_cycles(5);
    #1;
    total++; if (nwa !== 16'h1000 || nwb !== 16'h0005) begin bad++; $display("FAIL add_nw got=%h/%h exp=1000/0005", nwa, nwb); end
    total++; if (ea !== 6'h10 || eb !== 6'h1f) begin bad++; $display("FAIL add_fields got=%h/%h exp=10/1f", ea, eb); end
    total++; if (opc_q.size() != 1 || opc_q[0] !== 4'h2) begin bad++; $display("FAIL add_opc got=%h exp=2", opc_q[0]); end
    total++; if (fetch_q.size() != 3 || fetch_q[2] !== 16'h0002) begin bad++; $display("FAIL add_fetch got=%0d entries exp=3", fetch_q.size()); end
    total++; if (pc !== 16'h0003 || wb_cnt != 1) begin bad++; $display("FAIL add_pc got=%h wb=%0d exp=0003 wb=1", pc, wb_cnt); end
  endtask

  task automatic test_if_skip();
    clear_mem();
    mem[0] = 16'h800C; mem[1] = 16'h7C01;
    src = 16'h0005; tgt = 16'h0000;
    start();
    run_cycles(3);
    #1;
    total++; if (fetch_q.size() != 2 || fetch_q[1] !== 16'h0001) begin bad++; $display("FAIL ife_f_sk got=%0d entries exp=2", fetch_q.size()); end
    total++; if (pc !== 16'h0003) begin bad++; $display("FAIL ife_f_pc got=%h exp=0003", pc); end
    total++; if (alu_opc !== 4'hC || eb !== 6'h20) begin bad++; $display("FAIL ife_f_ir got=%h/%h exp=c/20", alu_opc, eb); end
    total++; if (wb_cnt != 0) begin bad++; $display("FAIL ife_f_wb got=%0d exp=0", wb_cnt); end
    run_cycles(1);
    total++; if (fetch_q.size() != 3 || fetch_q[2] !== 16'h0003) begin bad++; $display("FAIL ife_f_next got=%h exp=0003", fetch_q[2]); end
    src = 16'h0000; tgt = 16'h0000;
    start();
    run_cycles(2);
    #1;
    total++; if (bus_adr !== 16'h0001 || pc !== 16'h0001) begin bad++; $display("FAIL ife_t_next got=%h exp=0001", bus_adr); end
    total++; if (wb_cnt != 0 || alu_cnt != 1) begin bad++; $display("FAIL ife_t_strobes got=%0d/%0d exp=1/0", alu_cnt, wb_cnt); end
  endtask

  task automatic test_cond_table();
    logic [3:0]  opcs [0:8];
    logic [15:0] srcs [0:8];
    logic [15:0] tgts [0:8];
    logic        exps [0:8];
    opcs = '{4'hC,    4'hD,    4'hD,    4'hE,    4'hE,    4'hE,    4'hF,    4'hF,    4'hC};
    srcs = '{16'h5,   16'h5,   16'h1,   16'h8000,16'h7FFF,16'h5,   16'hF0,  16'h80,  16'hFFFF};
    tgts = '{16'h5,   16'h5,   16'h2,   16'h7FFF,16'h8000,16'h5,   16'h0F,  16'h81,  16'h7FFF};
    exps = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      mem[0] = {12'h800, opcs[i]};
      mem[1] = 16'h7C01;
      src = srcs[i]; tgt = tgts[i];
      start();
      run_cycles(3);
      #1;
      total++;
      if (pc !== (exps[i] ? 16'h0002 : 16'h0003) || alu_opc !== (exps[i] ? 4'h1 : opcs[i])) begin
        bad++;
        $display("FAIL cond_%0d opc=%h got pc=%h opc=%h exp pc=%h", i, opcs[i], pc, alu_opc, exps[i] ? 16'h0002 : 16'h0003);
      end
    end
    src = 16'h0; tgt = 16'h0;
  endtask

  task automatic test_wait_states();
    clear_mem();
    mem[0] = 16'h7C01; mem[1] = 16'h0030;
    ack_en = 1'b0;
    start();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus_stb !== 1'b1 || bus_adr !== 16'h0000 || alu_ena !== 1'b0 || pc !== 16'h0000) begin bad++; $display("FAIL wait_fe_%0d got=%b@%h ena=%b exp=1@0000 ena=0", i, bus_stb, bus_adr, alu_ena); end
      @(negedge clk);
    end
    ack_en = 1'b1;
    @(negedge clk);
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus_stb !== 1'b1 || bus_adr !== 16'h0001 || alu_ena !== 1'b0 || pc !== 16'h0001) begin bad++; $display("FAIL wait_nb_%0d got=%b@%h ena=%b exp=1@0001 ena=0", i, bus_stb, bus_adr, alu_ena); end
      @(negedge clk);
    end
    ack_en = 1'b1;
    run_cycles(3);
    #1;
    total++; if (alu_cnt != 1 || wb_cnt != 1 || nwb !== 16'h0030) begin bad++; $display("FAIL wait_done got=%0d/%0d nwb=%h exp=1/1 nwb=0030", alu_cnt, wb_cnt, nwb); end
    total++; if (pc !== 16'h0002 || fetch_q.size() != 2) begin bad++; $display("FAIL wait_pc got=%h n=%0d exp=0002 n=2", pc, fetch_q.size()); end
  endtask

  task automatic test_pc_write();
    clear_mem();
    mem[0] = {FLD_NWLIT, FLD_PC, 4'(OPC_SET)};
    mem[1] = 16'h0040;
    pc_wre = 1'b1; pc_dti = 16'h0040;
    start();
    run_cycles(4);
    #1;
    total++; if (bus_adr !== 16'h0040 || pc !== 16'h0040) begin bad++; $display("FAIL pcw_jump got=%h exp=0040", bus_adr); end
    total++; if (wb_cnt != 1) begin bad++; $display("FAIL pcw_wb got=%0d exp=1", wb_cnt); end
    pc_wre = 1'b0;
    clear_mem();
    mem[0] = {FLD_NWLIT, FLD_PC, 4'(OPC_SET)};
    mem[255] = 16'h0001;
    pc_wre = 1'b1; pc_dti = 16'hFFFF;
    start();
    run_cycles(4);
    #1;
    total++; if (bus_adr !== 16'hFFFF) begin bad++; $display("FAIL wrap_adr got=%h exp=ffff", bus_adr); end
    pc_wre = 1'b0;
    run_cycles(1);
    #1;
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    run_cycles(2);
    total++; if (fetch_q.size() != 3 || fetch_q[2] !== 16'hFFFF || bus_adr !== 16'h0000) begin bad++; $display("FAIL wrap_seq got n=%0d adr=%h exp n=3 adr=0000", fetch_q.size(), bus_adr); end
  endtask

  task automatic test_reset_na();
    clear_mem();
    mem[0] = 16'h7D02; mem[1] = 16'h1000; mem[2] = 16'h0005;
    start();
    run_cycles(1);
    #1;
    total++; if (bus_adr !== 16'h0001 || bus_stb !== 1'b1) begin bad++; $display("FAIL rna_pre got=%b@%h exp=1@0001", bus_stb, bus_adr); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus_stb !== 1'b0 || pc !== 16'h0000 || nwa !== 16'h0000) begin bad++; $display("FAIL rna_abort got=%b pc=%h nwa=%h exp=0 pc=0000 nwa=0000", bus_stb, pc, nwa); end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    run_cycles(5);
    #1;
    total++; if (pc !== 16'h0003 || nwa !== 16'h1000 || nwb !== 16'h0005) begin bad++; $display("FAIL rna_rerun got pc=%h nw=%h/%h exp 0003 1000/0005", pc, nwa, nwb); end
    total++; if (fetch_q.size() != 3 || fetch_q[0] !== 16'h0000 || wb_cnt != 1) begin bad++; $display("FAIL rna_seq got n=%0d wb=%0d exp n=3 wb=1", fetch_q.size(), wb_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mem();
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003;
    start();
    run_cycles(6);
    #1;
    total++; if (alu_cnt != 2 || wb_cnt != 2) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/2", alu_cnt, wb_cnt); end
    total++; if (opc_q.size() != 2 || opc_q[0] !== 4'h1 || opc_q[1] !== 4'h2) begin bad++; $display("FAIL b2b_opc got n=%0d exp 1,2", opc_q.size()); end
    total++; if (pc !== 16'h0002 || bus_adr !== 16'h0002) begin bad++; $display("FAIL b2b_pc got=%h exp=0002", pc); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_set();
    test_add();
    test_if_skip();
    test_cond_table();
    test_wait_states();
    test_pc_write();
    test_reset_na();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
